// File: rtl/video_timing.sv
// Raster timing generator with map-window flag; optional frame counter under VIDEO_TIMING_FRAME_COUNT_EN.
// Latency: outputs are registered and reflect the counter values loaded on the same pix_ce_i edge.
// Backpressure: none; pix_ce_i low freezes counters and outputs, and frame_start_o drops after one clk.
module video_timing #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int MAP_X0   = 64,
   parameter int MAP_Y0   = 48,
   parameter int MAP_W    = 512,
   parameter int MAP_H    = 384,
   parameter int SYNC_POL = 0,
   parameter int CNT_W    = 11
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             pix_ce_i,
   output logic             hsync_o,
   output logic             vsync_o,
   output logic             display_enable_o,
   output logic             map_enable_o,
   output logic [CNT_W-1:0] pixel_x_o,
   output logic [CNT_W-1:0] pixel_y_o,
   output logic             frame_start_o
`ifdef VIDEO_TIMING_FRAME_COUNT_EN
   ,
   output logic [15:0]      frame_cnt_o
`endif
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
   localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
   localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
   localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
   localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
   localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [CNT_W-1:0] MX_START = CNT_W'(MAP_X0);
   localparam logic [CNT_W-1:0] MX_END   = CNT_W'(MAP_X0 + MAP_W);
   localparam logic [CNT_W-1:0] MY_START = CNT_W'(MAP_Y0);
   localparam logic [CNT_W-1:0] MY_END   = CNT_W'(MAP_Y0 + MAP_H);
   localparam logic             SYNC_ACT = (SYNC_POL != 0);

   logic [CNT_W-1:0] h_cnt;
   logic [CNT_W-1:0] v_cnt;
   logic [CNT_W-1:0] h_nxt;
   logic [CNT_W-1:0] v_nxt;
   logic             de_nxt;
   logic             map_nxt;
   logic             hs_nxt;
   logic             vs_nxt;
   logic             fs_nxt;

   // Decode is done on the next counter values so every output lands with zero skew.
   always_comb begin
      h_nxt = h_cnt;
      v_nxt = v_cnt;
      if (h_cnt == H_LAST) begin
         h_nxt = '0;
         if (v_cnt == V_LAST) begin
            v_nxt = '0;
         end else begin
            v_nxt = v_cnt + 1'b1;
         end
      end else begin
         h_nxt = h_cnt + 1'b1;
      end

      de_nxt  = (h_nxt < H_ACT) && (v_nxt < V_ACT);
      map_nxt = de_nxt && (h_nxt >= MX_START) && (h_nxt < MX_END) &&
                (v_nxt >= MY_START) && (v_nxt < MY_END);
      hs_nxt  = ((h_nxt >= HS_START) && (h_nxt < HS_END)) ? SYNC_ACT : ~SYNC_ACT;
      vs_nxt  = ((v_nxt >= VS_START) && (v_nxt < VS_END)) ? SYNC_ACT : ~SYNC_ACT;
      fs_nxt  = (h_nxt == '0) && (v_nxt == '0);
   end

   // Reset parks the counters on the last pixel so the first ce edge wraps into a new frame.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         h_cnt            <= H_LAST;
         v_cnt            <= V_LAST;
         pixel_x_o        <= '0;
         pixel_y_o        <= '0;
         display_enable_o <= 1'b0;
         map_enable_o     <= 1'b0;
         hsync_o          <= ~SYNC_ACT;
         vsync_o          <= ~SYNC_ACT;
         frame_start_o    <= 1'b0;
`ifdef VIDEO_TIMING_FRAME_COUNT_EN
         frame_cnt_o      <= 16'd0;
`endif
      end else begin
         frame_start_o <= 1'b0;
         if (pix_ce_i) begin
            h_cnt            <= h_nxt;
            v_cnt            <= v_nxt;
            pixel_x_o        <= h_nxt;
            pixel_y_o        <= v_nxt;
            display_enable_o <= de_nxt;
            map_enable_o     <= map_nxt;
            hsync_o          <= hs_nxt;
            vsync_o          <= vs_nxt;
            frame_start_o    <= fs_nxt;
`ifdef VIDEO_TIMING_FRAME_COUNT_EN
            if (fs_nxt) begin
               frame_cnt_o <= frame_cnt_o + 16'd1;
            end
`endif
         end
      end
   end

endmodule

// File: tb/tb_video_timing.sv
// Bench for video_timing: a default-size instance and a small, positive-sync instance share rst/ce.
module tb_video_timing;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst = 1'b1;
   logic ce  = 1'b0;

   logic        a_hs, a_vs, a_de, a_map, a_fs;
   logic [10:0] a_x, a_y;
   logic        b_hs, b_vs, b_de, b_map, b_fs;
   logic [7:0]  b_x, b_y;
`ifdef VIDEO_TIMING_FRAME_COUNT_EN
   logic [15:0] a_fc, b_fc;
`endif

   video_timing u_a (
      .clk_i(clk), .rst_i(rst), .pix_ce_i(ce),
      .hsync_o(a_hs), .vsync_o(a_vs), .display_enable_o(a_de), .map_enable_o(a_map),
      .pixel_x_o(a_x), .pixel_y_o(a_y), .frame_start_o(a_fs)
`ifdef VIDEO_TIMING_FRAME_COUNT_EN
      , .frame_cnt_o(a_fc)
`endif
   );

   video_timing #(
      .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(4),
      .V_ACTIVE(10), .V_FP(2), .V_SYNC(2), .V_BP(3),
      .MAP_X0(3), .MAP_Y0(2), .MAP_W(8), .MAP_H(5),
      .SYNC_POL(1), .CNT_W(8)
   ) u_b (
      .clk_i(clk), .rst_i(rst), .pix_ce_i(ce),
      .hsync_o(b_hs), .vsync_o(b_vs), .display_enable_o(b_de), .map_enable_o(b_map),
      .pixel_x_o(b_x), .pixel_y_o(b_y), .frame_start_o(b_fs)
`ifdef VIDEO_TIMING_FRAME_COUNT_EN
      , .frame_cnt_o(b_fc)
`endif
   );

   typedef struct {
      int ha, hfp, hsw, hbp, va, vfp, vsw, vbp, mx, my, mw, mh, pol;
   } cfg_t;
   typedef struct {
      int x, y, de, map, hs, vs, fs, fc;
   } obs_t;
   typedef struct {
      int d, x, y, de, map, hs, vs, fs;
   } vec_t;

   cfg_t cfg [2];
   int   pos [2];
   bit   idle[2];
   bit   efs [2];
   int   efc [2];

   int tests = 0;
   int fails = 0;

   function automatic int total(int d);
      return (cfg[d].ha + cfg[d].hfp + cfg[d].hsw + cfg[d].hbp) *
             (cfg[d].va + cfg[d].vfp + cfg[d].vsw + cfg[d].vbp);
   endfunction

   // Reference: a linear pixel index per frame, split into (x,y) and classified by range.
   function automatic obs_t model_out(int d);
      obs_t o;
      cfg_t c = cfg[d];
      int   ht = c.ha + c.hfp + c.hsw + c.hbp;
      o.fs = int'(efs[d]);
      o.fc = efc[d];
      if (idle[d]) begin
         o.x = 0; o.y = 0; o.de = 0; o.map = 0;
         o.hs = 1 - c.pol; o.vs = 1 - c.pol;
      end else begin
         o.x   = pos[d] % ht;
         o.y   = pos[d] / ht;
         o.de  = (o.x < c.ha && o.y < c.va) ? 1 : 0;
         o.map = (o.de == 1 && o.x >= c.mx && o.x < c.mx + c.mw &&
                  o.y >= c.my && o.y < c.my + c.mh) ? 1 : 0;
         o.hs  = (o.x >= c.ha + c.hfp && o.x < c.ha + c.hfp + c.hsw) ? c.pol : 1 - c.pol;
         o.vs  = (o.y >= c.va + c.vfp && o.y < c.va + c.vfp + c.vsw) ? c.pol : 1 - c.pol;
      end
      return o;
   endfunction

   function automatic obs_t dut_out(int d);
      obs_t o;
      o.fc = 0;
      if (d == 0) begin
         o.x = int'(a_x); o.y = int'(a_y); o.de = int'(a_de); o.map = int'(a_map);
         o.hs = int'(a_hs); o.vs = int'(a_vs); o.fs = int'(a_fs);
`ifdef VIDEO_TIMING_FRAME_COUNT_EN
         o.fc = int'(a_fc);
`endif
      end else begin
         o.x = int'(b_x); o.y = int'(b_y); o.de = int'(b_de); o.map = int'(b_map);
         o.hs = int'(b_hs); o.vs = int'(b_vs); o.fs = int'(b_fs);
`ifdef VIDEO_TIMING_FRAME_COUNT_EN
         o.fc = int'(b_fc);
`endif
      end
      return o;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic compare_all(input int d);
      obs_t e = model_out(d);
      obs_t a = dut_out(d);
      check($sformatf("dut%0d pixel_x", d), a.x, e.x);
      check($sformatf("dut%0d pixel_y", d), a.y, e.y);
      check($sformatf("dut%0d display_enable", d), a.de, e.de);
      check($sformatf("dut%0d map_enable", d), a.map, e.map);
      check($sformatf("dut%0d hsync", d), a.hs, e.hs);
      check($sformatf("dut%0d vsync", d), a.vs, e.vs);
      check($sformatf("dut%0d frame_start", d), a.fs, e.fs);
`ifdef VIDEO_TIMING_FRAME_COUNT_EN
      check($sformatf("dut%0d frame_cnt", d), a.fc, e.fc);
`endif
   endtask

   task automatic tick(input bit r, input bit c);
      rst = r;
      ce  = c;
      @(posedge clk);
      for (int d = 0; d < 2; d++) begin
         if (r) begin
            pos[d] = total(d) - 1; idle[d] = 1'b1; efs[d] = 1'b0; efc[d] = 0;
         end else if (c) begin
            pos[d]  = (pos[d] + 1) % total(d);
            idle[d] = 1'b0;
            efs[d]  = (pos[d] == 0);
            if (efs[d]) efc[d] = (efc[d] + 1) % 65536;
         end else begin
            efs[d] = 1'b0;
         end
      end
      #1;
      compare_all(0);
      compare_all(1);
   endtask

   function automatic bit at_xy(int d, int x, int y);
      obs_t a = dut_out(d);
      return (a.x == x) && (a.y == y);
   endfunction

   task automatic seek(input int d, input int x, input int y);
      int n = 0;
      while (!at_xy(d, x, y) && n < 2000) begin
         tick(1'b0, 1'b1);
         n++;
      end
      if (!at_xy(d, x, y)) begin
         obs_t a = dut_out(d);
         tests++;
         fails++;
         $display("FAIL seek dut%0d: stopped at (%0d,%0d), wanted (%0d,%0d)", d, a.x, a.y, x, y);
      end
   endtask

   vec_t tbl[23];
   int   pulses;

   initial begin
      cfg[0] = '{640, 16, 96, 48, 480, 10, 2, 33, 64, 48, 512, 384, 0};
      cfg[1] = '{16, 2, 3, 4, 10, 2, 2, 3, 3, 2, 8, 5, 1};

      //         d   x    y  de map hs vs fs
      tbl[0]  = '{0, 639,  0, 1, 0, 1, 1, 0};
      tbl[1]  = '{0, 640,  0, 0, 0, 1, 1, 0};
      tbl[2]  = '{0, 655,  0, 0, 0, 1, 1, 0};
      tbl[3]  = '{0, 656,  0, 0, 0, 0, 1, 0};
      tbl[4]  = '{0, 751,  0, 0, 0, 0, 1, 0};
      tbl[5]  = '{0, 752,  0, 0, 0, 1, 1, 0};
      tbl[6]  = '{1,   2,  2, 1, 0, 0, 0, 0};
      tbl[7]  = '{1,   3,  2, 1, 1, 0, 0, 0};
      tbl[8]  = '{1,  10,  6, 1, 1, 0, 0, 0};
      tbl[9]  = '{1,  11,  6, 1, 0, 0, 0, 0};
      tbl[10] = '{1,   3,  7, 1, 0, 0, 0, 0};
      tbl[11] = '{1,  15,  9, 1, 0, 0, 0, 0};
      tbl[12] = '{1,  16,  9, 0, 0, 0, 0, 0};
      tbl[13] = '{1,  18,  9, 0, 0, 1, 0, 0};
      tbl[14] = '{1,  20,  9, 0, 0, 1, 0, 0};
      tbl[15] = '{1,  21,  9, 0, 0, 0, 0, 0};
      tbl[16] = '{1,  24,  9, 0, 0, 0, 0, 0};
      tbl[17] = '{1,   0, 10, 0, 0, 0, 0, 0};
      tbl[18] = '{1,   0, 12, 0, 0, 0, 1, 0};
      tbl[19] = '{1,  24, 13, 0, 0, 0, 1, 0};
      tbl[20] = '{1,   0, 14, 0, 0, 0, 0, 0};
      tbl[21] = '{1,  24, 16, 0, 0, 0, 0, 0};
      tbl[22] = '{1,   0,  0, 1, 0, 0, 0, 1};

      // Reset state and first frame start.
      tick(1'b1, 1'b0);
      tick(1'b1, 1'b1);
      check("reset a x", int'(a_x), 0);
      check("reset a de", int'(a_de), 0);
      check("reset a hsync idle", int'(a_hs), 1);
      check("reset b hsync idle", int'(b_hs), 0);
      check("reset a frame_start", int'(a_fs), 0);
      tick(1'b0, 1'b0);
      check("idle hold a x", int'(a_x), 0);
      check("idle hold a fs", int'(a_fs), 0);
      tick(1'b0, 1'b1);
      check("first ce a x", int'(a_x), 0);
      check("first ce a y", int'(a_y), 0);
      check("first ce a de", int'(a_de), 1);
      check("first ce a fs", int'(a_fs), 1);
      check("first ce b fs", int'(b_fs), 1);
      tick(1'b0, 1'b1);
      check("second ce a fs", int'(a_fs), 0);
      check("second ce a x", int'(a_x), 1);

      for (int i = 0; i < 23; i++) begin
         obs_t a;
         seek(tbl[i].d, tbl[i].x, tbl[i].y);
         a = dut_out(tbl[i].d);
         check($sformatf("tbl[%0d] de", i), a.de, tbl[i].de);
         check($sformatf("tbl[%0d] map", i), a.map, tbl[i].map);
         check($sformatf("tbl[%0d] hsync", i), a.hs, tbl[i].hs);
         check($sformatf("tbl[%0d] vsync", i), a.vs, tbl[i].vs);
         check($sformatf("tbl[%0d] frame_start", i), a.fs, tbl[i].fs);
      end

      // ce every 4th clk across a frame boundary: one-clk frame_start pulse.
      seek(1, 20, 16);
      pulses = 0;
      for (int i = 0; i < 40; i++) begin
         tick(1'b0, (i % 4) == 3);
         if (b_fs) pulses++;
      end
      check("slow ce frame_start width", pulses, 1);

      // Reset mid-frame, with ce high, abandons the frame.
      seek(1, 10, 5);
      tick(1'b1, 1'b1);
      check("midreset b x", int'(b_x), 0);
      check("midreset b y", int'(b_y), 0);
      check("midreset b de", int'(b_de), 0);
      check("midreset b hsync idle", int'(b_hs), 0);
      check("midreset b fs", int'(b_fs), 0);
      tick(1'b0, 1'b0);
      tick(1'b0, 1'b1);
      check("restart b x", int'(b_x), 0);
      check("restart b y", int'(b_y), 0);
      check("restart b de", int'(b_de), 1);
      check("restart b fs", int'(b_fs), 1);
      check("restart a fs", int'(a_fs), 1);

      // Randomised ce and occasional reset against the reference model.
      for (int i = 0; i < 4000; i++) begin
         tick($urandom_range(0, 299) == 0, $urandom_range(0, 3) != 0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
